lut_neuron_loader: RTL and testbench
====================================

# lut_neuron_loader

Runtime-programmable 8-input, 1-output neuron lookup table for the MNIST LogicNets ensemble datapath. It is the write-side counterpart of the fixed ROM neurons: a 256-entry truth table is streamed in over a valid/ready configuration port, then served to the layer datapath with a registered, one-cycle lookup. It lets a trained neuron be swapped on-chip without resynthesis, and it sits in place of one fixed layer neuron.

## Interface
Parameters:
- `LUT_IN`, 8: neuron input width. The table holds 2^LUT_IN entries.
- `CFG_W`, 8: configuration word width. Each word carries `CFG_W` table entries.
- `N_WORDS`, 2^LUT_IN / CFG_W = 32: number of words in one load.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `cfg_data`, in, 8: one table word.
- `cfg_valid`, in, 1: `cfg_data` is valid.
- `cfg_last`, in, 1: marks the final word of a load.
- `cfg_ready`, out, 1: the block accepts a word this cycle.
- `armed`, out, 1: a complete table is loaded and lookups are live.
- `cfg_err`, out, 1: one-cycle pulse on a malformed load.
- `M0`, in, 8: neuron input code.
- `in_valid`, in, 1: `M0` is valid.
- `M1`, out, 1: neuron output.
- `out_valid`, out, 1: `M1` is valid.

## Operation
- A word is **accepted** when `cfg_valid` and `cfg_ready` are both high. `cfg_ready` is always 1 out of reset. The block never back-pressures.
- **Table layout:** word index w (0..31) with bit b (0..7) writes entry k = 8w+b. Entry k is the response to `M0` = bitrev8(k). Example: k=1 is M0=8'b10000000, and k=128 is M0=8'b00000001. This matches the enumeration order the generator emits.
- **State machine:**
  - IDLE: unarmed.
    - Accepted word with `cfg_last`=0 → LOAD. The word is written as w=0.
    - Accepted word with `cfg_last`=1 → write the word, pulse `cfg_err`, stay IDLE.
  - LOAD: each accepted word writes at the word counter, then the counter increments.
    - Counter=31 and `cfg_last`=1 → ARMED.
    - Counter=31 and `cfg_last`=0 → `cfg_err`, go to IDLE.
    - Counter<31 and `cfg_last`=1 → `cfg_err`, go to IDLE.
  - ARMED: an accepted word starts a new load.
    - `armed` drops the cycle after acceptance.
    - The word is written as w=0 and the state goes to LOAD.
    - Rewrite is in place. There is no shadow table.
- **Lookup:**
  - When `in_valid` is high, the next cycle gives `out_valid`=1 and `M1` = table[bitrev8(M0)] if `armed`, else 0.
  - `armed` is sampled in the same cycle as `M0`.
  - When `in_valid` is low, the next cycle gives `out_valid`=0 and `M1` holds its value.
- **Simultaneous events:**
  - A lookup in the same cycle as a write to the entry it addresses returns the old value (read before write).
  - A lookup in the cycle a reload is accepted still sees `armed`=1 and returns the old table content.
- The table is never cleared. Stale entries remain until overwritten and are masked by `armed`=0.

## Timing
- **Reset values:** state IDLE, word counter 0, `armed` 0, `cfg_err` 0, `M1` 0, `out_valid` 0, `cfg_ready` 1. Table contents are undefined (no reset on the table).
- **Reset mid-load:** the block returns to IDLE and the partial load is discarded. A fresh 32-word load is required.
- **Lookup latency:** exactly 1 cycle, fully pipelined, throughput 1 lookup per cycle.
- **Configuration throughput:** 1 word per cycle. `armed` rises the cycle after the last word is accepted, so a full load takes 32 cycles plus 1.
- **`cfg_err`:** high for exactly 1 cycle, in the cycle after the offending word. `armed` stays 0 after an error.

## Structure
- Shared package `lut_neuron_pkg` holds:
  - `LUT_IN`, `CFG_W`, `N_WORDS`;
  - the state enum (IDLE/LOAD/ARMED);
  - a `bitrev8` function.
- Sub-module `lut_table_256x1` contains:
  - 256×1 distributed storage;
  - a write port that takes an 8-bit word at a 5-bit word address;
  - a registered read port with a 1-bit output.
- The top level contains the FSM, the word counter, the error logic and the valid pipeline.

## Test plan
- **After reset:** `in_valid`=1, M0=8'hA5 → next cycle `out_valid`=1, `M1`=0, `armed`=0, `cfg_ready`=1.
- **All-ones table:** load 32 words of 8'hFF with `cfg_last` on word 31 → `armed`=1 at cycle 33. Sweep all 256 M0 codes back-to-back → `M1`=1 every cycle, `out_valid` held high.
- **Ordering check:** load words 8'h01 → M0=8'h01 returns 1 (k=128), M0=8'h10 returns 1 (k=8), M0=8'h80 returns 0 (k=1).
- **Early last:** `cfg_last` on word 10 → `cfg_err` pulses once, `armed`=0, lookups return 0. A following full load arms normally.
- **Reload while armed:** first word of a new load accepted → `armed`=0 the next cycle. A lookup issued in the acceptance cycle returns the old value.
- **Mid-load reset:** assert `rst_n`=0 at word 20 → IDLE. The next 32-word load arms, and the remaining words of the interrupted stream are not counted.

Source files
------------

// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the runtime-programmable LogicNets neuron LUT.
//   LUT_IN   : neuron input width (table holds 2^LUT_IN one-bit entries)
//   CFG_W    : table entries carried by one configuration word
//   N_WORDS  : configuration words in one complete load
//   state_e  : loader state (IDLE / LOAD / ARMED)
//   bitrev8  : maps a neuron input code to its table entry index and back
package lut_neuron_pkg;

  localparam int LUT_IN  = 8;
  localparam int CFG_W   = 8;
  localparam int N_ENTRY = 1 << LUT_IN;
  localparam int N_WORDS = N_ENTRY / CFG_W;
  localparam int WADDR_W = $clog2(N_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_e;

  // The generator enumerates entries with the neuron code bit-reversed:
  // entry k answers the input code bitrev8(k).
  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[7-i];
    end
    return r;
  endfunction

endpackage : lut_neuron_pkg

// File: rtl/lut_table_256x1.sv
// 256 x 1 distributed truth table with a word-wide write port and a
// registered single-bit read port.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we_i       : write wdata_i into word waddr_i (entries 8*waddr_i + b)
//   waddr_i    : word address
//   wdata_i    : eight table entries, bit b -> entry 8*waddr_i + b
//   re_i       : capture a lookup this cycle
//   raddr_i    : entry index to read
//   rgate_i    : when low the captured lookup result is forced to 0
//   rdata_o    : registered lookup result, holds while re_i is low
module lut_table_256x1
  import lut_neuron_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [WADDR_W-1:0] waddr_i,
  input  logic [CFG_W-1:0]   wdata_i,
  input  logic               re_i,
  input  logic [LUT_IN-1:0]  raddr_i,
  input  logic               rgate_i,
  output logic               rdata_o
);

  logic [CFG_W-1:0] mem_q [N_WORDS];
  logic             rdata_q;

  // NOTE: the storage array has no reset; clearing it would prevent a
  // distributed-RAM mapping, and stale content is masked by the armed gate.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reading the array at the same edge that writes it returns the old
  // entry, giving read-before-write behaviour for colliding accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 1'b0;
    end else if (re_i) begin
      rdata_q <= rgate_i & mem_q[raddr_i[LUT_IN-1:3]][raddr_i[2:0]];
    end
  end

  assign rdata_o = rdata_q;

endmodule : lut_table_256x1

// File: rtl/lut_neuron_loader.sv
// Runtime-loadable 8-input / 1-output neuron lookup table.
// A 256-entry truth table is streamed in as 32 eight-bit words over a
// valid/ready port; once a complete, well-formed load has landed the table
// answers lookups with a one-cycle registered latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_data   : configuration word (8 table entries)
//   cfg_valid  : cfg_data is valid
//   cfg_last   : final word of a load
//   cfg_ready  : word accepted this cycle (never back-pressures)
//   armed      : complete table present, lookups are live
//   cfg_err    : one-cycle pulse after a malformed load word
//   M0         : neuron input code
//   in_valid   : M0 is valid
//   M1         : neuron output
//   out_valid  : M1 is valid
module lut_neuron_loader
  import lut_neuron_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              cfg_valid,
  input  logic              cfg_last,
  output logic              cfg_ready,
  output logic              armed,
  output logic              cfg_err,
  input  logic [LUT_IN-1:0] M0,
  input  logic              in_valid,
  output logic              M1,
  output logic              out_valid
);

  state_e             state_q, state_d;
  logic [WADDR_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               out_valid_q;
  logic [WADDR_W-1:0] waddr;
  logic               accept;

  assign cfg_ready = 1'b1;
  assign accept    = cfg_valid & cfg_ready;
  assign armed     = (state_q == ARMED);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    waddr   = '0;
    unique case (state_q)
      // From IDLE or ARMED an accepted word always lands at word 0 and
      // opens a new load; a lone word flagged last is a malformed load.
      IDLE, ARMED: begin
        if (accept) begin
          if (cfg_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = WADDR_W'(1);
          end
        end
      end
      LOAD: begin
        waddr = cnt_q;
        if (accept) begin
          if (cnt_q == WADDR_W'(N_WORDS - 1)) begin
            cnt_d = '0;
            if (cfg_last) begin
              state_d = ARMED;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (cfg_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + WADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= in_valid;
    end
  end

  assign cfg_err   = err_q;
  assign out_valid = out_valid_q;

  // The armed gate is the registered state, so a lookup issued in the
  // cycle a reload is accepted still sees the old, armed table.
  lut_table_256x1 u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .waddr_i (waddr),
    .wdata_i (cfg_data),
    .re_i    (in_valid),
    .raddr_i (bitrev8(M0)),
    .rgate_i (armed),
    .rdata_o (M1)
  );

endmodule : lut_neuron_loader

// File: tb/tb_lut_neuron_loader.sv
// Scoreboard bench for lut_neuron_loader. The driver applies one cycle of
// stimulus per falling edge and pushes the outputs expected after the next
// rising edge; the monitor samples #1 after each rising edge and compares.
module tb_lut_neuron_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_last = 1'b0;
  logic       cfg_ready;
  logic       armed;
  logic       cfg_err;
  logic [7:0] M0 = '0;
  logic       in_valid = 1'b0;
  logic       M1;
  logic       out_valid;

  always #5 clk = ~clk;

  lut_neuron_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_last  (cfg_last),
    .cfg_ready (cfg_ready),
    .armed     (armed),
    .cfg_err   (cfg_err),
    .M0        (M0),
    .in_valid  (in_valid),
    .M1        (M1),
    .out_valid (out_valid)
  );

  typedef struct {
    int due;
    bit vld;
    bit m1;
    bit arm;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // ---------------- reference model (entry-indexed truth table) ----------
  bit tbl[256];
  bit m_loading;   // a load is in progress
  int m_words;     // words already received in the current load
  bit m_armed;
  bit m_m1;

  function automatic int entry_of(input logic [7:0] code);
    logic [7:0] r;
    r = {<<{code}};
    return int'(r);
  endfunction

  task automatic check(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // One configuration/lookup cycle plus the model step that predicts it.
  task automatic step(input bit v, input logic [7:0] d, input bit l,
                      input bit iv, input logic [7:0] m, input bit rst);
    exp_t e;
    int   w;
    @(negedge clk);
    cfg_valid = v;
    cfg_data  = d;
    cfg_last  = l;
    in_valid  = iv;
    M0        = m;
    rst_n     = !rst;
    e.due = cyc + 1;
    e.err = 1'b0;
    if (rst) begin
      m_loading = 1'b0;
      m_words   = 0;
      m_armed   = 1'b0;
      m_m1      = 1'b0;
      e.vld     = 1'b0;
    end else begin
      e.vld = iv;
      if (iv) m_m1 = m_armed ? tbl[entry_of(m)] : 1'b0;
      if (v) begin
        w = m_loading ? m_words : 0;
        for (int b = 0; b < 8; b++) tbl[8*w + b] = d[b];
        m_armed = 1'b0;
        if (!m_loading) begin
          if (l) e.err = 1'b1;
          else begin
            m_loading = 1'b1;
            m_words   = 1;
          end
        end else begin
          m_words++;
          if (m_words == 32) begin
            m_loading = 1'b0;
            if (l) m_armed = 1'b1;
            else   e.err   = 1'b1;
          end else if (l) begin
            m_loading = 1'b0;
            e.err     = 1'b1;
          end
        end
      end
    end
    e.m1  = m_m1;
    e.arm = m_armed;
    sb.push_back(e);
  endtask

  task automatic idle_cycle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Send n words; cfg_last rides on word last_at (-1: never). When rnd is
  // set the data are random, otherwise every word is fill. Random lookups
  // are interleaved with the stream.
  task automatic load(input int n, input int last_at, input bit rnd,
                      input logic [7:0] fill);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : fill;
      step(1'b1, d, i == last_at, 1'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  // ---------------- monitor ----------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("out_valid", out_valid, e.vld);
        check("M1", M1, e.m1);
        check("armed", armed, e.arm);
        check("cfg_err", cfg_err, e.err);
        check("cfg_ready", cfg_ready, 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ---------------------------------------------
  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

    // Lookup straight after reset: unarmed, answers 0.
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
    idle_cycle();

    // All-ones table, then a back-to-back sweep of every code.
    load(32, 31, 1'b0, 8'hFF);
    for (int i = 0; i < 256; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 1'b0);

    // Reload while armed: the lookup in the acceptance cycle hits entry 0,
    // which this word overwrites, and must still return the old 1.
    step(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    load(31, 30, 1'b0, 8'h01);

    // Ordering: only bit 0 of each word is set.
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    idle_cycle();

    // Early last on word 10, probe, then a normal load arms again.
    load(11, 10, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0);
    load(32, 31, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0);

    // Missing last on word 31.
    load(32, -1, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0);

    // Reset in the middle of a load, then a fresh load.
    load(20, -1, 1'b1, 8'h00);
    step(1'b1, 8'h55, 1'b0, 1'b1, 8'h12, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    load(32, 31, 1'b1, 8'h00);
    for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0);

    // Random traffic: loads of random shape with gaps and lookups mixed in.
    for (int r = 0; r < 40; r++) begin
      int last_at;
      last_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 31;
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 4) == 0)
          step(1'b0, 8'h00, 1'b0, 1'($urandom), 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), i == last_at, 1'($urandom), 8'($urandom), 1'b0);
        if (i == last_at) break;
      end
      for (int i = 0; i < 24; i++)
        step(1'b0, 8'h00, 1'b0, 1'($urandom), 8'($urandom), 1'b0);
    end

    idle_cycle();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lut_neuron_loader
